debug_ctrl: RTL

Debug command controller that sits directly upstream of the datapath's coprocessor IO port and downstream of a byte-stream host link (UART or JTAG bridge). It decodes host commands to halt, resume and single-step the core, and reads or writes architectural registers through the datapath's debug register-file port. It also converts the datapath's `breakSrc` break request into a core halt and records the cause.

---
 rtl/debug_ctrl.sv | 270 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/debug_ctrl.sv
// Host-link debug command controller: halt/resume/step of the core, register
// file read/write through the coprocessor IO port, and break-request capture.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | waiting for an opcode byte
// S_GET_IDX   | waiting for the register index operand
// S_GET_DATA  | collecting NB write-data bytes, LSB first
// S_RD_ADDR   | register index driven with read-active
// S_RD_CAPT   | read data captured into the shift register
// S_WR_STROBE | one-cycle register write strobe
// S_STEP_RUN  | core released for exactly one cycle
// S_TX_HDR    | sending the 0xA4 read header
// S_TX_DATA   | sending NB read-data bytes, LSB first
// S_TX_ACK    | sending a single-byte ack / status / error response

module debug_ctrl #(
    parameter int N = 64
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic [7:0]   rxData_i,
    input  logic         rxValid_i,
    output logic         rxReady_o,
    output logic [7:0]   txData_o,
    output logic         txValid_o,
    input  logic         txReady_i,
    input  logic [1:0]   breakSrc_i,
    output logic [14:0]  coprocessorIOAddr_o,
    output logic [2:0]   coprocessorIOControl_o,
    output logic [N-1:0] coprocessorIODataOut_o,
    input  logic [N-1:0] coprocessorIODataIn_i,
    output logic         cpuHalt_o,
    output logic [1:0]   breakCause_o
);

    localparam int NB = N / 8;
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;

    localparam logic [7:0] OP_HALT   = 8'h01;
    localparam logic [7:0] OP_RESUME = 8'h02;
    localparam logic [7:0] OP_STEP   = 8'h03;
    localparam logic [7:0] OP_RDREG  = 8'h10;
    localparam logic [7:0] OP_WRREG  = 8'h11;
    localparam logic [7:0] OP_STATUS = 8'h20;

    localparam logic [7:0] RSP_HALT   = 8'hA1;
    localparam logic [7:0] RSP_RESUME = 8'hA2;
    localparam logic [7:0] RSP_STEP   = 8'hA3;
    localparam logic [7:0] RSP_RDHDR  = 8'hA4;
    localparam logic [7:0] RSP_WRACK  = 8'hA5;
    localparam logic [7:0] RSP_ERR    = 8'hEE;

    typedef enum logic [3:0] {
        S_IDLE,
        S_GET_IDX,
        S_GET_DATA,
        S_RD_ADDR,
        S_RD_CAPT,
        S_WR_STROBE,
        S_STEP_RUN,
        S_TX_HDR,
        S_TX_DATA,
        S_TX_ACK
    } state_t;

    state_t        state_q;
    logic          is_wr_q;
    logic [4:0]    idx_q;
    logic [CW-1:0] cnt_q;
    logic [N-1:0]  shift_q;
    logic [7:0]    tx_data_q;
    logic          tx_valid_q;
    logic [4:0]    addr_q;
    logic          rd_q;
    logic          wr_q;
    logic [N-1:0]  dout_q;
    logic          halt_q;
    logic [1:0]    cause_q;

    logic          rx_fire;
    logic          tx_fire;
    logic          resume_fire;
    logic [N-1:0]  wdata_d;

    assign rxReady_o   = (state_q == S_IDLE) || (state_q == S_GET_IDX) || (state_q == S_GET_DATA);
    assign rx_fire     = rxValid_i && rxReady_o;
    assign tx_fire     = tx_valid_q && txReady_i;
    assign resume_fire = (state_q == S_IDLE) && rx_fire && (rxData_i == OP_RESUME);

    // Incoming bytes enter at the top so the first (LSB) byte ends up at [7:0].
    assign wdata_d = (shift_q >> 8) | (N'(rxData_i) << (N - 8));

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            is_wr_q    <= 1'b0;
            idx_q      <= '0;
            cnt_q      <= '0;
            shift_q    <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            addr_q     <= '0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            dout_q     <= '0;
            halt_q     <= 1'b0;
            cause_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (rx_fire) begin
                        case (rxData_i)
                            OP_HALT: begin
                                halt_q     <= 1'b1;
                                tx_data_q  <= RSP_HALT;
                                tx_valid_q <= 1'b1;
                                state_q    <= S_TX_ACK;
                            end
                            OP_RESUME: begin
                                halt_q     <= 1'b0;
                                cause_q    <= '0;
                                tx_data_q  <= RSP_RESUME;
                                tx_valid_q <= 1'b1;
                                state_q    <= S_TX_ACK;
                            end
                            OP_STEP: begin
                                if (halt_q) begin
                                    halt_q  <= 1'b0;
                                    state_q <= S_STEP_RUN;
                                end else begin
                                    tx_data_q  <= RSP_ERR;
                                    tx_valid_q <= 1'b1;
                                    state_q    <= S_TX_ACK;
                                end
                            end
                            OP_RDREG, OP_WRREG: begin
                                is_wr_q <= (rxData_i == OP_WRREG);
                                state_q <= S_GET_IDX;
                            end
                            OP_STATUS: begin
                                tx_data_q  <= {5'b0, halt_q, cause_q};
                                tx_valid_q <= 1'b1;
                                state_q    <= S_TX_ACK;
                            end
                            default: begin
                                tx_data_q  <= RSP_ERR;
                                tx_valid_q <= 1'b1;
                                state_q    <= S_TX_ACK;
                            end
                        endcase
                    end
                end

                S_GET_IDX: begin
                    if (rx_fire) begin
                        idx_q <= rxData_i[4:0];
                        if (is_wr_q) begin
                            cnt_q   <= '0;
                            state_q <= S_GET_DATA;
                        end else if (halt_q) begin
                            addr_q  <= rxData_i[4:0];
                            rd_q    <= 1'b1;
                            state_q <= S_RD_ADDR;
                        end else begin
                            tx_data_q  <= RSP_ERR;
                            tx_valid_q <= 1'b1;
                            state_q    <= S_TX_ACK;
                        end
                    end
                end

                S_GET_DATA: begin
                    if (rx_fire) begin
                        shift_q <= wdata_d;
                        if (cnt_q == CW'(NB - 1)) begin
                            // The halt check is made once all operands are in.
                            if (halt_q) begin
                                addr_q  <= idx_q;
                                dout_q  <= wdata_d;
                                wr_q    <= 1'b1;
                                state_q <= S_WR_STROBE;
                            end else begin
                                tx_data_q  <= RSP_ERR;
                                tx_valid_q <= 1'b1;
                                state_q    <= S_TX_ACK;
                            end
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end

                S_RD_ADDR: begin
                    state_q <= S_RD_CAPT;
                end

                S_RD_CAPT: begin
                    shift_q    <= coprocessorIODataIn_i;
                    rd_q       <= 1'b0;
                    cnt_q      <= '0;
                    tx_data_q  <= RSP_RDHDR;
                    tx_valid_q <= 1'b1;
                    state_q    <= S_TX_HDR;
                end

                S_WR_STROBE: begin
                    wr_q       <= 1'b0;
                    tx_data_q  <= RSP_WRACK;
                    tx_valid_q <= 1'b1;
                    state_q    <= S_TX_ACK;
                end

                S_STEP_RUN: begin
                    halt_q     <= 1'b1;
                    tx_data_q  <= RSP_STEP;
                    tx_valid_q <= 1'b1;
                    state_q    <= S_TX_ACK;
                end

                S_TX_HDR: begin
                    if (tx_fire) begin
                        tx_data_q <= shift_q[7:0];
                        shift_q   <= shift_q >> 8;
                        state_q   <= S_TX_DATA;
                    end
                end

                S_TX_DATA: begin
                    if (tx_fire) begin
                        if (cnt_q == CW'(NB - 1)) begin
                            tx_valid_q <= 1'b0;
                            state_q    <= S_IDLE;
                        end else begin
                            tx_data_q <= shift_q[7:0];
                            shift_q   <= shift_q >> 8;
                            cnt_q     <= cnt_q + CW'(1);
                        end
                    end
                end

                S_TX_ACK: begin
                    if (tx_fire) begin
                        tx_valid_q <= 1'b0;
                        state_q    <= S_IDLE;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase

            // A break overrides a same-cycle RESUME and also lands during STEP_RUN.
            if ((breakSrc_i != 2'b00) && (!halt_q || resume_fire)) begin
                halt_q  <= 1'b1;
                cause_q <= breakSrc_i;
            end
        end
    end

    assign txData_o               = tx_data_q;
    assign txValid_o              = tx_valid_q;
    assign coprocessorIOAddr_o    = {10'd0, addr_q};
    assign coprocessorIOControl_o = {1'b0, rd_q, wr_q};
    assign coprocessorIODataOut_o = dout_q;
    assign cpuHalt_o              = halt_q;
    assign breakCause_o           = cause_q;

endmodule
